// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame geometry.
// Used by uart_rx; uart_tx pulls the same constants so both ends agree.
package uart_pkg;

    // Default bit period in system clock cycles.
    localparam int DEFAULT_BIT_CLK = 87;

    // Payload bits per 8N1 frame.
    localparam int DATA_BITS = 8;

    // Index of the last payload bit (width matches the 3-bit bit index).
    localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

    // Receiver/transmitter FSM states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_e;

    // Mid-bit sample point of the start bit for a given bit period.
    function automatic int half_bit(input int bit_clk);
        return (bit_clk - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side handshake of the UART receiver: byte holding register,
// valid/ack pair and the one-cycle status pulses.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rxdata;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    // Receiver drives data and status, samples the ack.
    modport master (
        output rxdata,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy,
        input  rx_ack
    );

    // Byte consumer (command parser, loopback) side.
    modport slave (
        input  rxdata,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy,
        output rx_ack
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. The reset value
// is a parameter so an idle-high line does not look like a start bit
// coming out of reset.
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage metastability filter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Samples the synchronized line mid-bit, assembles bytes
// LSB-first and hands them over through a valid/ack holding register.
// Stop-bit errors raise frame_err; a byte finishing while the previous one
// is still unacknowledged raises overrun and is dropped.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BIT_CLK = DEFAULT_BIT_CLK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    uart_rx_if.master  bus
);

    localparam int HALF  = half_bit(BIT_CLK);
    localparam int CNT_W = $clog2(BIT_CLK);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLK - 1);

    logic                 rxd_s;

    uart_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2:0]           idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rxdata_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 busy_q;

    logic                 accept_d;
    logic                 ack_clr_d;

    uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rxd),
        .q_o (rxd_s)
    );

    // Holding register can take a new byte when empty or being drained now.
    always_comb begin
        accept_d  = !rx_valid_q || bus.rx_ack;
        ack_clr_d = rx_valid_q && bus.rx_ack;
    end

    // Frame FSM with registered data, handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rxdata_q    <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            // A delivery later in this block overrides the clear.
            if (ack_clr_d)
                rx_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rxd_s) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end

                // Re-check the start bit at its middle to reject glitches.
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (!rxd_s) begin
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                // One full bit period after the start mid-point lands mid-bit.
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rxd_s;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == LAST_BIT_IDX)
                            state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                // Return to IDLE right after the stop sample so a
                // back-to-back start bit is still caught.
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (rxd_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            if (accept_d) begin
                                rxdata_q   <= shift_q;
                                rx_valid_q <= 1'b1;
                            end else begin
                                overrun_q  <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                // A held-low line (break) must not retrigger START.
                WAIT_HIGH: begin
                    cnt_q <= '0;
                    if (rxd_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rxdata    = rxdata_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx. Frames are generated as ideal
// 8N1 waveforms at a chosen bit period; the expected holding-register
// contents and flag counts come from a frame-level model of the
// valid/ack/overrun/frame-error rules.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BC = 87;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;

    uart_rx_if bus ();

    uart_rx #(.BIT_CLK(BC)) dut (
        .clk (clk),
        .rst (rst),
        .rxd (rxd),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Pulse counters, sampled away from the active edge.
    int fe_seen = 0;
    int ov_seen = 0;
    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) fe_seen++;
        if (bus.overrun   === 1'b1) ov_seen++;
    end

    // Reference model state.
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    int         exp_fe    = 0;
    int         exp_ov    = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level outcome of a completed frame.
    task automatic model_frame(input logic [7:0] d, input logic stop, input logic ack_at_stop);
        if (!stop)
            exp_fe++;
        else if (!exp_valid || ack_at_stop) begin
            exp_data  = d;
            exp_valid = 1'b1;
        end else
            exp_ov++;
    endtask

    // Start bit plus 8 data bits, LSB first.
    task automatic send_head(input logic [7:0] d, input int period);
        rxd = 1'b0;
        tick(period);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick(period);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int period, input logic stop);
        send_head(d, period);
        rxd = stop;
        tick(period);
        rxd = 1'b1;
    endtask

    task automatic ack_pulse();
        bus.rx_ack = 1'b1;
        tick(1);
        bus.rx_ack = 1'b0;
        exp_valid  = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".valid"}, 32'(bus.rx_valid), 32'(exp_valid));
        if (exp_valid)
            chk({tag, ".data"}, 32'(bus.rxdata), 32'(exp_data));
        chk({tag, ".fe"}, 32'(fe_seen), 32'(exp_fe));
        chk({tag, ".ov"}, 32'(ov_seen), 32'(exp_ov));
    endtask

    initial begin
        logic [7:0] d;
        int         per;

        bus.rx_ack = 1'b0;

        // Reset state.
        tick(3);
        chk("rst.rxdata", 32'(bus.rxdata), 32'h0);
        chk("rst.valid", 32'(bus.rx_valid), 32'h0);
        chk("rst.fe", 32'(bus.frame_err), 32'h0);
        chk("rst.ov", 32'(bus.overrun), 32'h0);
        chk("rst.busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        tick(5);

        // 0xA5 at nominal timing: valid appears exactly after edge 3+HALF+9*BC.
        send_head(8'hA5, BC);
        rxd = 1'b1;
        tick(46);
        chk("a5.valid_early", 32'(bus.rx_valid), 32'h0);
        chk("a5.busy", 32'(bus.busy), 32'h1);
        tick(1);
        model_frame(8'hA5, 1'b1, 1'b0);
        chk("a5.valid_on_time", 32'(bus.rx_valid), 32'h1);
        chk("a5.data", 32'(bus.rxdata), 32'hA5);
        chk("a5.busy_done", 32'(bus.busy), 32'h0);
        tick(40);
        chk_state("a5");
        ack_pulse();
        chk("a5.ack_clears", 32'(bus.rx_valid), 32'h0);

        // Glitch on the line: 20 low cycles is rejected at the start mid-point.
        rxd = 1'b0;
        tick(10);
        chk("glitch.busy_hi", 32'(bus.busy), 32'h1);
        tick(10);
        rxd = 1'b1;
        tick(40);
        chk("glitch.busy_lo", 32'(bus.busy), 32'h0);
        chk_state("glitch");

        // Framing error followed by a long break.
        send_head(8'h3C, BC);
        rxd = 1'b0;
        tick(BC + 500);
        model_frame(8'h3C, 1'b0, 1'b0);
        chk("ferr.busy_in_break", 32'(bus.busy), 32'h1);
        chk_state("ferr");
        rxd = 1'b1;
        tick(10);
        chk("ferr.busy_after", 32'(bus.busy), 32'h0);
        chk_state("ferr_after");

        // Back-to-back with no ack: second byte overruns.
        send_frame(8'h11, BC, 1'b1);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, BC, 1'b1);
        model_frame(8'h22, 1'b1, 1'b0);
        tick(5);
        chk("ovr.data_kept", 32'(bus.rxdata), 32'h11);
        chk_state("ovr");
        ack_pulse();

        // Back-to-back with ack on the second stop-sample cycle.
        send_frame(8'h11, BC, 1'b1);
        model_frame(8'h11, 1'b1, 1'b0);
        send_head(8'h22, BC);
        rxd = 1'b1;
        tick(46);
        bus.rx_ack = 1'b1;
        tick(1);
        bus.rx_ack = 1'b0;
        model_frame(8'h22, 1'b1, 1'b1);
        tick(40);
        chk("ackstop.data", 32'(bus.rxdata), 32'h22);
        chk_state("ackstop");
        ack_pulse();

        // +-2% bit period.
        send_frame(8'hFF, 85, 1'b1);
        model_frame(8'hFF, 1'b1, 1'b0);
        tick(3);
        chk_state("ff85");
        ack_pulse();
        send_frame(8'h00, 89, 1'b1);
        model_frame(8'h00, 1'b1, 1'b0);
        tick(3);
        chk_state("0089");
        ack_pulse();
        send_frame(8'hFF, 89, 1'b1);
        model_frame(8'hFF, 1'b1, 1'b0);
        tick(3);
        chk_state("ff89");
        ack_pulse();
        send_frame(8'h00, 85, 1'b1);
        model_frame(8'h00, 1'b1, 1'b0);
        tick(3);
        chk_state("0085");

        // Random bytes, periods, gaps and acks.
        for (int i = 0; i < 10; i++) begin
            d   = 8'($urandom);
            per = int'($urandom_range(85, 89));
            if ($urandom_range(0, 1) == 1) ack_pulse();
            tick(int'($urandom_range(1, 20)));
            send_frame(d, per, 1'b1);
            model_frame(d, 1'b1, 1'b0);
            tick(2);
            chk_state("rand");
        end

        // Reset mid-DATA abandons the frame; a clean frame follows.
        ack_pulse();
        send_frame(8'h33, BC, 1'b1);
        model_frame(8'h33, 1'b1, 1'b0);
        tick(2);
        chk("pre_rst.valid", 32'(bus.rx_valid), 32'h1);
        rxd = 1'b0;
        tick(BC);
        rxd = 1'b0;
        tick(BC);
        rxd = 1'b1;
        tick(50);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst.rxdata", 32'(bus.rxdata), 32'h0);
        chk("mid_rst.valid", 32'(bus.rx_valid), 32'h0);
        chk("mid_rst.busy", 32'(bus.busy), 32'h0);
        chk("mid_rst.fe", 32'(bus.frame_err), 32'h0);
        chk("mid_rst.ov", 32'(bus.overrun), 32'h0);
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        tick(2);
        rst = 1'b0;
        tick(20);
        send_frame(8'h5A, BC, 1'b1);
        model_frame(8'h5A, 1'b1, 1'b0);
        tick(3);
        chk("post_rst.data", 32'(bus.rxdata), 32'h5A);
        chk_state("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's uart_tx, using the same BIT_CLK bit-timing convention (clock cycles per bit).
- Samples asynchronous serial line rxd, recovers bytes LSB-first and presents each byte on a valid/ack holding register.
- Flags framing errors and overruns.
- Sits between the board RX pin and the byte consumer (command parser / loopback to uart_tx).

Parameters:
- BIT_CLK, 87: clock cycles per bit period; legal range 4..256.
- HALF, (BIT_CLK-1)/2 (localparam, integer division): START-state count at which the start bit is re-checked (43 for default).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rxd  in  1  serial input, idle high, asynchronous to clk.
- rxdata  out  8  last received byte; stable while rx_valid=1.
- rx_valid  out  1  byte available; level, held until acknowledged.
- rx_ack  in  1  consumer accepts rxdata; clears rx_valid on the next edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while rx_valid=1 and rx_ack=0; the new byte is discarded.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; counters clear.
  - Both synchronizer flops are set to 1.
  - rxdata=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame abandons the frame; no flags are produced.
- Synchronizer: rxd passes through 2 flops to give rxd_s. Only rxd_s is used by the FSM.
- Counter width: $clog2(BIT_CLK) bits. The bit index is 3 bits.
- IDLE: when rxd_s==0, go to START with count=0.
- START: count+1 per cycle. At count==HALF:
  - rxd_s==0 -> DATA, count=0, index=0.
  - rxd_s==1 -> IDLE (glitch rejected, no flag).
- DATA: count+1 per cycle. At count==BIT_CLK-1:
  - shift[index] <= rxd_s, count=0, index+1.
  - After index 7 is sampled -> STOP.
- STOP: count+1 per cycle. At count==BIT_CLK-1, sample rxd_s:
  - rxd_s==1: deliver the byte -> IDLE.
  - rxd_s==0: frame_err pulse, byte discarded, rx_valid unchanged -> WAIT_HIGH.
- WAIT_HIGH: stay until rxd_s==1, then go to IDLE. This stops a held-low line (break) from retriggering START.
- Delivery:
  - If rx_valid==0, or rx_ack==1 in the same cycle: rxdata<=shift, rx_valid<=1.
  - Otherwise: overrun pulse; rxdata and rx_valid keep the old byte.
- Ack: rx_ack with rx_valid=1 clears rx_valid next edge. rx_ack with rx_valid=0 is ignored.
- Latency: let edge 0 be the first clk edge at which rxd is low.
  - START is entered at edge 2.
  - DATA is entered at edge 3+HALF.
  - Bit n is sampled at edge 3+HALF+(n+1)*BIT_CLK.
  - rx_valid is high after edge 3+HALF+9*BIT_CLK (829 for default).
- Back-to-back frames: a start bit immediately after the stop sample is accepted. IDLE is re-entered right after the stop-sample edge, giving up to a 0.5 bit of slack.
- Illegal state encodings -> IDLE.

Decomposition:
- Package uart_pkg:
  - State encodings IDLE/START/DATA/STOP/WAIT_HIGH.
  - DEFAULT_BIT_CLK=87.
  - DATA_BITS=8.
  - Shared with uart_tx.
- Sub-module uart_rx_sync: 2-flop synchronizer with async reset-to-1, parameterised reset value.

Test Plan:
- Byte 0xA5 at exact BIT_CLK=87 timing -> rx_valid rises after edge 829, rxdata=0xA5, frame_err=0, overrun=0; rx_ack one cycle -> rx_valid=0 next edge.
- rxd low pulse of 20 cycles, then high -> START aborts at count 43, back to IDLE; no rx_valid, no flags; busy drops.
- Byte 0x3C with the stop bit driven 0, then line held low for 500 cycles before going high -> one frame_err pulse; rx_valid stays 0; no second frame until rxd returns high.
- Two frames 0x11 then 0x22 back-to-back, no rx_ack -> rxdata=0x11 remains, overrun pulses once at the second stop sample.
- Repeat with rx_ack asserted on the second stop-sample cycle -> no overrun, rxdata=0x22, rx_valid stays 1.
- Bit period stretched/shrunk by ±2% (85 and 89 cycles) for 0xFF and 0x00 -> both received correctly.
- rst asserted mid-DATA of 0x5A -> all outputs 0 immediately; the following clean 0x5A frame is received correctly.
